// File: rtl/chirp_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// chirp_sequencer: steps the chirp generator through a table of profiles,
// reprogramming it and pulsing its reset between profiles.
// Optional feature macro: CHIRP_SEQ_LOOP_EN (adds the loop input).
// Revision: 1.0
// ---------------------------------------------------------------------------
module chirp_sequencer #(
  parameter int N    = 32,
  parameter int PROF = 4,
  parameter int AW   = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic [2:0]    cfg_field,
  input  logic [N-1:0]  cfg_wdata,
  input  logic          start,
  input  logic          stop,
  input  logic [AW-1:0] last_prof,
`ifdef CHIRP_SEQ_LOOP_EN
  input  logic          loop,
`endif
  input  logic          chirp_wrap,
  output logic [N-1:0]  min_ctrl,
  output logic [N-1:0]  max_ctrl,
  output logic [N-1:0]  inc_rate,
  output logic [N-1:0]  div_rate,
  output logic          reverse,
  output logic [7:0]    delay,
  output logic          gen_rst,
  output logic          busy,
  output logic [AW-1:0] prof_idx,
  output logic          seq_done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_SETTLE = 2'd2,
    S_RUN    = 2'd3
  } state_t;

  logic [N-1:0] min_tbl_q [PROF];
  logic [N-1:0] max_tbl_q [PROF];
  logic [N-1:0] inc_tbl_q [PROF];
  logic [N-1:0] div_tbl_q [PROF];
  logic [7:0]   rep_tbl_q [PROF];
  logic [7:0]   dly_tbl_q [PROF];
  logic         rev_tbl_q [PROF];

  state_t       state_q, state_d;
  logic [AW-1:0] prof_q, prof_d;
  logic [AW-1:0] last_q, last_d;
  logic [7:0]   cnt_q, cnt_d;
  logic         done_q, done_d;
  logic [N-1:0] min_q, max_q, inc_q, div_q;
  logic [7:0]   rep_q, dly_q;
  logic         rev_q;
  logic         load_en;
  logic [AW-1:0] load_idx;
  logic [7:0]   w_eff_rep;
  logic         w_loop;

`ifdef CHIRP_SEQ_LOOP_EN
  assign w_loop = loop;
`else
  assign w_loop = 1'b0;
`endif

  // Profile table has no reset; software programs it before use.
  always_ff @(posedge clk) begin
    if (cfg_we) begin
      case (cfg_field)
        3'd0: min_tbl_q[cfg_addr] <= cfg_wdata;
        3'd1: max_tbl_q[cfg_addr] <= cfg_wdata;
        3'd2: inc_tbl_q[cfg_addr] <= cfg_wdata;
        3'd3: div_tbl_q[cfg_addr] <= cfg_wdata;
        3'd4: begin
          rep_tbl_q[cfg_addr] <= cfg_wdata[7:0];
          dly_tbl_q[cfg_addr] <= cfg_wdata[15:8];
          rev_tbl_q[cfg_addr] <= cfg_wdata[16];
        end
        default: ;
      endcase
    end
  end

  assign w_eff_rep = (rep_q == 8'd0) ? 8'd1 : rep_q;

  // Config is loaded on the transition into LOAD so it is valid during LOAD.
  always_comb begin
    state_d  = state_q;
    prof_d   = prof_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    load_en  = 1'b0;
    load_idx = '0;
    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          state_d  = S_LOAD;
          prof_d   = '0;
          last_d   = last_prof;
          load_en  = 1'b1;
          load_idx = '0;
        end
      end
      S_LOAD: begin
        cnt_d   = '0;
        state_d = stop ? S_IDLE : S_SETTLE;
      end
      S_SETTLE: begin
        state_d = stop ? S_IDLE : S_RUN;
      end
      S_RUN: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (chirp_wrap) begin
          if (cnt_q + 8'd1 == w_eff_rep) begin
            if (prof_q != last_q) begin
              state_d  = S_LOAD;
              prof_d   = prof_q + AW'(1);
              load_en  = 1'b1;
              load_idx = prof_q + AW'(1);
            end else if (w_loop) begin
              state_d  = S_LOAD;
              prof_d   = '0;
              load_en  = 1'b1;
              load_idx = '0;
            end else begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      prof_q  <= '0;
      last_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      min_q   <= '0;
      max_q   <= '0;
      inc_q   <= '0;
      div_q   <= '0;
      rep_q   <= '0;
      dly_q   <= '0;
      rev_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prof_q  <= prof_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      if (load_en) begin
        min_q <= min_tbl_q[load_idx];
        max_q <= max_tbl_q[load_idx];
        inc_q <= inc_tbl_q[load_idx];
        div_q <= div_tbl_q[load_idx];
        rep_q <= rep_tbl_q[load_idx];
        dly_q <= dly_tbl_q[load_idx];
        rev_q <= rev_tbl_q[load_idx];
      end
    end
  end

  assign min_ctrl = min_q;
  assign max_ctrl = max_q;
  assign inc_rate = inc_q;
  assign div_rate = div_q;
  assign reverse  = rev_q;
  assign delay    = dly_q;
  assign gen_rst  = (state_q != S_RUN);
  assign busy     = (state_q != S_IDLE);
  assign prof_idx = prof_q;
  assign seq_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_chirp_sequencer.sv
`default_nettype none
// Testbench for chirp_sequencer: vector table, directed sequences and
// randomized traffic against a profile-level reference model.
module tb_chirp_sequencer;
  localparam int N    = 32;
  localparam int AW   = 2;
  localparam int PROF = 4;

  logic          clk = 1'b0;
  logic          rst, cfg_we, start, stop, chirp_wrap;
  logic [AW-1:0] cfg_addr, last_prof;
  logic [2:0]    cfg_field;
  logic [N-1:0]  cfg_wdata;
`ifdef CHIRP_SEQ_LOOP_EN
  logic          loop;
`endif
  logic [N-1:0]  min_ctrl, max_ctrl, inc_rate, div_rate;
  logic          reverse, gen_rst, busy, seq_done;
  logic [7:0]    delay;
  logic [AW-1:0] prof_idx;

  int checks = 0;
  int errors = 0;

  chirp_sequencer #(.N(N), .PROF(PROF), .AW(AW)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_field(cfg_field), .cfg_wdata(cfg_wdata), .start(start), .stop(stop),
    .last_prof(last_prof),
`ifdef CHIRP_SEQ_LOOP_EN
    .loop(loop),
`endif
    .chirp_wrap(chirp_wrap), .min_ctrl(min_ctrl), .max_ctrl(max_ctrl),
    .inc_rate(inc_rate), .div_rate(div_rate), .reverse(reverse), .delay(delay),
    .gen_rst(gen_rst), .busy(busy), .prof_idx(prof_idx), .seq_done(seq_done)
  );

  always #5 clk = ~clk;

  // Reference model: profile table plus "reset cycles left" and "wraps left".
  logic [N-1:0] t_min [PROF], t_max [PROF], t_inc [PROF], t_div [PROF];
  logic [7:0]   t_rep [PROF], t_dly [PROF];
  logic         t_rev [PROF];
  logic [N-1:0] e_min, e_max, e_inc, e_div;
  logic [7:0]   e_dly;
  logic         e_rev;
  bit           m_busy, m_done;
  int           m_gap, m_left, m_prof, m_last;

  function automatic bit loop_v();
`ifdef CHIRP_SEQ_LOOP_EN
    return loop;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_load(input int p);
    e_min = t_min[p]; e_max = t_max[p]; e_inc = t_inc[p]; e_div = t_div[p];
    e_dly = t_dly[p]; e_rev = t_rev[p];
    m_left = (t_rep[p] == 8'd0) ? 1 : int'(t_rep[p]);
    m_gap  = 2;
  endtask

  task automatic model_step();
    m_done = 1'b0;
    if (rst) begin
      e_min = '0; e_max = '0; e_inc = '0; e_div = '0; e_dly = '0; e_rev = 1'b0;
      m_busy = 1'b0; m_prof = 0; m_gap = 0;
    end else if (!m_busy) begin
      if (start && !stop) begin
        m_busy = 1'b1; m_prof = 0; m_last = int'(last_prof);
        model_load(0);
      end
    end else if (stop) begin
      m_busy = 1'b0;
    end else if (m_gap > 0) begin
      m_gap--;
    end else if (chirp_wrap) begin
      m_left--;
      if (m_left == 0) begin
        if (m_prof != m_last) begin
          m_prof++; model_load(m_prof);
        end else if (loop_v()) begin
          m_prof = 0; model_load(0);
        end else begin
          m_busy = 1'b0; m_done = 1'b1;
        end
      end
    end
    if (cfg_we) begin
      case (cfg_field)
        3'd0: t_min[cfg_addr] = cfg_wdata;
        3'd1: t_max[cfg_addr] = cfg_wdata;
        3'd2: t_inc[cfg_addr] = cfg_wdata;
        3'd3: t_div[cfg_addr] = cfg_wdata;
        3'd4: begin
          t_rep[cfg_addr] = cfg_wdata[7:0];
          t_dly[cfg_addr] = cfg_wdata[15:8];
          t_rev[cfg_addr] = cfg_wdata[16];
        end
        default: ;
      endcase
    end
  endtask

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic check_model();
    chk("model_cfg", {min_ctrl, max_ctrl, inc_rate, div_rate, delay, reverse},
        {e_min, e_max, e_inc, e_div, e_dly, e_rev});
    chk("model_ctl", {busy, gen_rst, prof_idx, seq_done},
        {m_busy, !(m_busy && m_gap == 0), AW'(m_prof), m_done});
  endtask

  // Inputs change at negedge; model advances at posedge; outputs checked at negedge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model();
  endtask

  task automatic write_slot(input int a, input logic [N-1:0] mn, input logic [N-1:0] mx,
                            input logic [N-1:0] inc, input logic [N-1:0] dv,
                            input logic [N-1:0] misc);
    for (int f = 0; f < 5; f++) begin
      cfg_we    = 1'b1;
      cfg_addr  = a[AW-1:0];
      cfg_field = f[2:0];
      cfg_wdata = (f == 0) ? mn : (f == 1) ? mx : (f == 2) ? inc : (f == 3) ? dv : misc;
      cycle();
    end
    cfg_we = 1'b0;
  endtask

  typedef struct {
    logic start, stop, wrap;
    logic busy, grst, done;
  } vec_t;

  function automatic vec_t mk(logic s, logic p, logic w, logic b, logic g, logic d);
    vec_t v;
    v.start = s; v.stop = p; v.wrap = w; v.busy = b; v.grst = g; v.done = d;
    return v;
  endfunction

  vec_t vecs[$];
  int   n, nsw, ngr, ndone;
  bit   seen;
  logic [AW-1:0] prev;

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_field = '0; cfg_wdata = '0;
    start = 1'b0; stop = 1'b0; chirp_wrap = 1'b0; last_prof = '0;
`ifdef CHIRP_SEQ_LOOP_EN
    loop = 1'b0;
`endif
    for (int p = 0; p < PROF; p++) begin
      t_min[p] = '0; t_max[p] = '0; t_inc[p] = '0; t_div[p] = '0;
      t_rep[p] = '0; t_dly[p] = '0; t_rev[p] = 1'b0;
    end
    @(negedge clk);
    cycle(); cycle();
    chk("rst_ctl", {busy, gen_rst, prof_idx, seq_done}, {1'b0, 1'b1, 2'd0, 1'b0});
    chk("rst_cfg", {min_ctrl, max_ctrl, inc_rate, div_rate, delay, reverse}, '0);
    rst = 1'b0;

    write_slot(0, 32'h100, 32'h400, 32'h10, 32'h3, 32'h2);
    write_slot(1, 32'h111, 32'h411, 32'h11, 32'h4, 32'h0001_0501);
    write_slot(2, 32'h222, 32'h422, 32'h12, 32'h5, 32'h0000_0701);
    write_slot(3, 32'h333, 32'h433, 32'h13, 32'h6, 32'h0001_0901);

    // start/stop/wrap -> busy, gen_rst, seq_done (slot0 repeat=2, last_prof=0)
    vecs.push_back(mk(1, 0, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 1, 1, 1, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 1, 0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 1, 1));
    last_prof = '0;
    for (int i = 0; i < vecs.size(); i++) begin
      start = vecs[i].start; stop = vecs[i].stop; chirp_wrap = vecs[i].wrap;
      cycle();
      chk($sformatf("vec%0d", i), {busy, gen_rst, seq_done, prof_idx},
          {vecs[i].busy, vecs[i].grst, vecs[i].done, 2'd0});
      if (i == 0)
        chk("vec0_cfg", {min_ctrl, max_ctrl, inc_rate, div_rate, delay, reverse},
            {32'h100, 32'h400, 32'h10, 32'h3, 8'h0, 1'b0});
    end
    start = 1'b0; stop = 1'b0; chirp_wrap = 1'b0;

    // Three profiles, repeats 1,3,0, wrap every cycle.
    write_slot(0, 32'h100, 32'h400, 32'h10, 32'h3, 32'h1);
    write_slot(1, 32'h111, 32'h411, 32'h11, 32'h4, 32'h3);
    write_slot(2, 32'h222, 32'h422, 32'h12, 32'h5, 32'h0);
    last_prof = 2'd2; start = 1'b1;
    cycle();
    start = 1'b0; chirp_wrap = 1'b1;
    n = 0; nsw = 0; ngr = 1; seen = 1'b0; prev = prof_idx;
    while (!seen && n < 40) begin
      cycle(); n++;
      if (busy && gen_rst) ngr++;
      if (prof_idx != prev) nsw++;
      prev = prof_idx;
      if (seq_done) seen = 1'b1;
    end
    chirp_wrap = 1'b0;
    chk("t3_done", seen, 1'b1);
    chk("t3_len", n, 11);
    chk("t3_switches", nsw, 2);
    chk("t3_grst_cycles", ngr, 6);
    chk("t3_final_prof", prof_idx, 2'd2);

    // Write to the active profile waits for its next load.
    write_slot(0, 32'h100, 32'h400, 32'h10, 32'h3, 32'h1);
    write_slot(1, 32'h111, 32'h400, 32'h11, 32'h4, 32'h2);
    last_prof = 2'd1; start = 1'b1;
    cycle();
    start = 1'b0; chirp_wrap = 1'b1; n = 0;
    while (!(busy && prof_idx == 2'd1) && n < 20) begin cycle(); n++; end
    chirp_wrap = 1'b0;
    cycle(); cycle();
    chk("t5_run", {busy, gen_rst, prof_idx}, {1'b1, 1'b0, 2'd1});
    cfg_we = 1'b1; cfg_addr = 2'd1; cfg_field = 3'd1; cfg_wdata = 32'h800;
    cycle();
    cfg_we = 1'b0;
    cycle();
    chk("t5_hold", max_ctrl, 32'h400);
    chirp_wrap = 1'b1; n = 0;
    while (busy && n < 20) begin cycle(); n++; end
    chirp_wrap = 1'b0;
    start = 1'b1;
    cycle();
    start = 1'b0; chirp_wrap = 1'b1; n = 0;
    while (!(busy && prof_idx == 2'd1) && n < 20) begin cycle(); n++; end
    chk("t5_reload", max_ctrl, 32'h800);
    while (busy && n < 40) begin cycle(); n++; end
    chirp_wrap = 1'b0;
    chk("t5_idle", busy, 1'b0);

`ifdef CHIRP_SEQ_LOOP_EN
    write_slot(0, 32'h100, 32'h400, 32'h10, 32'h3, 32'h1);
    write_slot(1, 32'h111, 32'h411, 32'h11, 32'h4, 32'h1);
    last_prof = 2'd1; loop = 1'b1; start = 1'b1;
    cycle();
    start = 1'b0; chirp_wrap = 1'b1;
    nsw = 0; ndone = 0; prev = prof_idx;
    for (int k = 0; k < 30; k++) begin
      cycle();
      if (prof_idx != prev) nsw++;
      prev = prof_idx;
      if (seq_done) ndone++;
    end
    chk("t6_loop_nodone", ndone, 0);
    chk("t6_loop_busy", busy, 1'b1);
    chk("t6_loop_switches", nsw >= 3, 1'b1);
    loop = 1'b0; n = 0; seen = 1'b0;
    while (!seen && n < 20) begin cycle(); n++; if (seq_done) seen = 1'b1; end
    chirp_wrap = 1'b0;
    chk("t6_done", seen, 1'b1);
    chk("t6_done_prof", prof_idx, 2'd1);
`endif

    // Randomized traffic, checked every cycle by the model.
    for (int k = 0; k < 4000; k++) begin
      rst       = ($urandom % 250) == 0;
      cfg_we    = ($urandom % 8) == 0;
      cfg_addr  = AW'($urandom);
      cfg_field = 3'($urandom);
      cfg_wdata = $urandom;
      if (cfg_field == 3'd4) cfg_wdata[7:0] = 8'($urandom_range(0, 4));
      start      = ($urandom % 8) == 0;
      stop       = ($urandom % 80) == 0;
      chirp_wrap = ($urandom % 2) == 0;
      last_prof  = AW'($urandom);
`ifdef CHIRP_SEQ_LOOP_EN
      loop = ($urandom % 3) != 0;
`endif
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
